// File: rtl/pa_AsyncCordic.sv
// Shared types and helpers for the dual-rail CORDIC/sqrt datapath and its front-ends.
package pa_AsyncCordic;

  typedef struct packed {
    logic data_1;
    logic data_0;
  } dual_rail_t;

  localparam dual_rail_t DR_NULL = '{data_1: 1'b0, data_0: 1'b0};

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DRIVE    = 3'd1,
    RTZ      = 3'd2,
    WAIT_RES = 3'd3,
    RES_ACK  = 3'd4,
    RESP     = 3'd5
  } sched_state_t;

  // Single-bit dual-rail encode: 1 -> {1,0}, 0 -> {0,1}.
  function automatic dual_rail_t dr_encode(input logic b);
    dual_rail_t d;
    d.data_1 = b;
    d.data_0 = ~b;
    return d;
  endfunction

  // A codeword is legal data only when exactly one rail is high.
  function automatic logic dr_is_valid(input dual_rail_t d);
    return d.data_1 ^ d.data_0;
  endfunction

endpackage

// File: rtl/async_sync_ff.sv
// Multi-flop synchronizer bringing an asynchronous level into the clk domain.
module async_sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic arst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  // Shift the async level through the flop chain; clears with the shared reset.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
    end
  end

  assign q = r_sync[STAGES-1];

endmodule

// File: rtl/async_sqrt_scheduler.sv
// Clocked front-end sharing one asynchronous dual-rail sqrt datapath among N_REQ requesters.
module async_sqrt_scheduler import pa_AsyncCordic::*; #(
  parameter  int unsigned N_REQ          = 4,
  parameter  int unsigned SIZE           = 16,
  parameter  int unsigned SYNC_STAGES    = 2,
  parameter  int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned ID_W           = $clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      arst,
  input  logic [N_REQ-1:0]          req_valid_i,
  input  logic [N_REQ*(SIZE+1)-1:0] req_data_i,
  output logic [N_REQ-1:0]          req_ready_o,
  output dual_rail_t [SIZE:0]       dr_data_o,
  input  logic                      dr_ack_i,
  input  dual_rail_t [SIZE:0]       dr_result_i,
  input  logic                      dr_result_done_i,
  output logic                      dr_result_ack_o,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [ID_W-1:0]           rsp_id_o,
  output logic [SIZE:0]             rsp_data_o,
  output logic                      err_timeout_o,
  output logic                      err_rail_o
);

  localparam int unsigned DW    = SIZE + 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  sched_state_t        r_state, w_state_nxt;
  logic [N_REQ-1:0]    r_ready, w_ready_nxt;
  dual_rail_t [SIZE:0] r_dr_data, w_dr_data_nxt;
  logic                r_res_ack, w_res_ack_nxt;
  logic                r_rsp_valid, w_rsp_valid_nxt;
  logic [ID_W-1:0]     r_rsp_id, w_rsp_id_nxt;
  logic [SIZE:0]       r_rsp_data, w_rsp_data_nxt;
  logic [ID_W-1:0]     r_gnt, w_gnt_nxt;
  logic [ID_W-1:0]     r_rr_ptr, w_rr_ptr_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_err_to, w_err_to_nxt;
  logic                r_err_rail, w_err_rail_nxt;

  logic                w_ack_s, w_done_s;
  logic                w_hi_vld, w_lo_vld, w_gnt_vld;
  logic [ID_W-1:0]     w_hi_idx, w_lo_idx, w_gnt_idx;
  logic [SIZE:0]       w_operand;
  logic [SIZE:0]       w_res_data;
  logic                w_rail_bad;

  async_sync_ff #(.STAGES(SYNC_STAGES)) u_sync_ack (
    .clk (clk), .arst(arst), .d(dr_ack_i), .q(w_ack_s)
  );

  async_sync_ff #(.STAGES(SYNC_STAGES)) u_sync_done (
    .clk (clk), .arst(arst), .d(dr_result_done_i), .q(w_done_s)
  );

  // Round-robin pick: first valid at/after rr_ptr, else first valid from index 0.
  always_comb begin
    w_hi_vld  = 1'b0;
    w_hi_idx  = '0;
    w_lo_vld  = 1'b0;
    w_lo_idx  = '0;
    w_operand = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!w_hi_vld && req_valid_i[i] && (ID_W'(i) >= r_rr_ptr)) begin
        w_hi_vld = 1'b1;
        w_hi_idx = ID_W'(i);
      end
      if (!w_lo_vld && req_valid_i[i]) begin
        w_lo_vld = 1'b1;
        w_lo_idx = ID_W'(i);
      end
    end
    w_gnt_vld = w_hi_vld | w_lo_vld;
    w_gnt_idx = w_hi_vld ? w_hi_idx : w_lo_idx;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_gnt_idx == ID_W'(i)) w_operand = req_data_i[i*DW +: DW];
    end
  end

  // Decode result data rails and flag any bit whose rails are equal.
  always_comb begin
    w_res_data = '0;
    w_rail_bad = 1'b0;
    for (int unsigned i = 0; i <= SIZE; i++) begin
      w_res_data[i] = dr_result_i[i].data_1;
      if (!dr_is_valid(dr_result_i[i])) w_rail_bad = 1'b1;
    end
  end

  // Next-state and next-output logic for the handshake sequencer and timeout watchdog.
  always_comb begin
    w_state_nxt     = r_state;
    w_ready_nxt     = '0;
    w_dr_data_nxt   = r_dr_data;
    w_res_ack_nxt   = r_res_ack;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_id_nxt    = r_rsp_id;
    w_rsp_data_nxt  = r_rsp_data;
    w_gnt_nxt       = r_gnt;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_err_rail_nxt  = r_err_rail;
    w_err_to_nxt    = r_err_to;
    w_cnt_nxt       = '0;

    case (r_state)
      IDLE: begin
        if (w_gnt_vld && !w_ack_s && !w_done_s) begin
          w_ready_nxt[w_gnt_idx] = 1'b1;
          w_gnt_nxt              = w_gnt_idx;
          w_rr_ptr_nxt           = (w_gnt_idx == ID_W'(N_REQ - 1)) ? '0 : w_gnt_idx + ID_W'(1);
          for (int unsigned i = 0; i <= SIZE; i++) begin
            w_dr_data_nxt[i] = dr_encode(w_operand[i]);
          end
          w_state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        if (w_ack_s) begin
          for (int unsigned i = 0; i <= SIZE; i++) begin
            w_dr_data_nxt[i] = DR_NULL;
          end
          w_state_nxt = RTZ;
        end
      end
      RTZ: begin
        if (!w_ack_s) w_state_nxt = WAIT_RES;
      end
      WAIT_RES: begin
        if (w_done_s) begin
          w_rsp_data_nxt = w_res_data;
          if (w_rail_bad) w_err_rail_nxt = 1'b1;
          w_res_ack_nxt = 1'b1;
          w_state_nxt   = RES_ACK;
        end
      end
      RES_ACK: begin
        if (!w_done_s) begin
          w_res_ack_nxt   = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_id_nxt    = r_gnt;
          w_state_nxt     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Watchdog counts only while stalled in a handshake state; saturates at the limit.
    if ((w_state_nxt == r_state) && (r_state inside {DRIVE, RTZ, WAIT_RES, RES_ACK})) begin
      w_cnt_nxt = (r_cnt == CNT_W'(TIMEOUT_CYCLES)) ? r_cnt : r_cnt + CNT_W'(1);
    end
    if (w_cnt_nxt == CNT_W'(TIMEOUT_CYCLES)) w_err_to_nxt = 1'b1;
  end

  // State and registered-output update with asynchronous clear.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_state     <= IDLE;
      r_ready     <= '0;
      r_dr_data   <= '0;
      r_res_ack   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_gnt       <= '0;
      r_rr_ptr    <= '0;
      r_cnt       <= '0;
      r_err_to    <= 1'b0;
      r_err_rail  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ready     <= w_ready_nxt;
      r_dr_data   <= w_dr_data_nxt;
      r_res_ack   <= w_res_ack_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_id    <= w_rsp_id_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_gnt       <= w_gnt_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_err_to    <= w_err_to_nxt;
      r_err_rail  <= w_err_rail_nxt;
    end
  end

  assign req_ready_o     = r_ready;
  assign dr_data_o       = r_dr_data;
  assign dr_result_ack_o = r_res_ack;
  assign rsp_valid_o     = r_rsp_valid;
  assign rsp_id_o        = r_rsp_id;
  assign rsp_data_o      = r_rsp_data;
  assign err_timeout_o   = r_err_to;
  assign err_rail_o      = r_err_rail;

endmodule

// File: tb/tb_async_sqrt_scheduler.sv
// Bench for async_sqrt_scheduler with a behavioural four-phase dual-rail sqrt datapath.
module tb_async_sqrt_scheduler;
  import pa_AsyncCordic::*;

  localparam int N_REQ = 4;
  localparam int SIZE  = 16;
  localparam int DW    = SIZE + 1;

  logic                 clk;
  logic                 arst;
  logic [N_REQ-1:0]     req_valid_i;
  logic [N_REQ*DW-1:0]  req_data_i;
  logic [N_REQ-1:0]     req_ready_o;
  dual_rail_t [SIZE:0]  dr_data_o;
  logic                 dr_ack_i;
  dual_rail_t [SIZE:0]  dr_result_i;
  logic                 dr_result_done_i;
  logic                 dr_result_ack_o;
  logic                 rsp_valid_o;
  logic                 rsp_ready_i;
  logic [1:0]           rsp_id_o;
  logic [SIZE:0]        rsp_data_o;
  logic                 err_timeout_o;
  logic                 err_rail_o;

  logic [SIZE:0]        req_op [N_REQ];

  int n_checks = 0;
  int n_err    = 0;

  async_sqrt_scheduler #(
    .N_REQ(N_REQ), .SIZE(SIZE), .SYNC_STAGES(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .arst(arst),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
    .dr_data_o(dr_data_o), .dr_ack_i(dr_ack_i),
    .dr_result_i(dr_result_i), .dr_result_done_i(dr_result_done_i),
    .dr_result_ack_o(dr_result_ack_o),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_id_o(rsp_id_o), .rsp_data_o(rsp_data_o),
    .err_timeout_o(err_timeout_o), .err_rail_o(err_rail_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) req_data_i[i*DW +: DW] = req_op[i];
  end

  function automatic logic [2*DW-1:0] bench_enc(input logic [SIZE:0] v);
    logic [2*DW-1:0] e;
    for (int i = 0; i < DW; i++) begin
      e[2*i+1] = v[i];
      e[2*i]   = ~v[i];
    end
    return e;
  endfunction

  function automatic logic [SIZE:0] bench_dec(input logic [2*DW-1:0] e);
    logic [SIZE:0] v;
    for (int i = 0; i < DW; i++) v[i] = e[2*i+1];
    return v;
  endfunction

  function automatic logic all_valid(input logic [2*DW-1:0] e);
    for (int i = 0; i < DW; i++) if (e[2*i+1] == e[2*i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [SIZE:0] isqrt(input logic [SIZE:0] v);
    int r = 0;
    while ((r + 1) * (r + 1) <= int'(v)) r++;
    return DW'(r);
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Behavioural async datapath: ack after 3 cycles, result once returned to zero.
  int              m_st;
  int              m_cnt;
  logic            m_ack_en;
  logic [SIZE:0]   m_corrupt;
  logic [SIZE:0]   m_op;
  logic [2*DW-1:0] m_enc;
  logic            m_unstable;
  int              m_log[$];

  always @(negedge clk or negedge arst) begin
    if (!arst) begin
      m_st             <= 0;
      m_cnt            <= 0;
      dr_ack_i         <= 1'b0;
      dr_result_done_i <= 1'b0;
      dr_result_i      <= '0;
    end else begin
      case (m_st)
        0: if (all_valid(dr_data_o)) begin
             m_op  <= bench_dec(dr_data_o);
             m_enc <= dr_data_o;
             m_cnt <= 0;
             m_st  <= 1;
           end
        1: if (m_ack_en) begin
             if (m_cnt == 2) begin
               dr_ack_i <= 1'b1;
               m_log.push_back(1);
               m_st <= 2;
             end else m_cnt <= m_cnt + 1;
           end
        2: if (dr_data_o == '0) begin
             m_log.push_back(2);
             m_st <= 3;
           end else if (dr_data_o != m_enc) m_unstable <= 1'b1;
        3: begin
             dr_ack_i <= 1'b0;
             m_log.push_back(3);
             begin
               logic [2*DW-1:0] res;
               res = bench_enc(isqrt(m_op));
               for (int i = 0; i < DW; i++) if (m_corrupt[i]) res[2*i+1 -: 2] = 2'b11;
               dr_result_i <= res;
             end
             m_cnt <= 0;
             m_st  <= 4;
           end
        4: if (m_cnt == 1) begin
             dr_result_done_i <= 1'b1;
             m_log.push_back(4);
             m_st <= 5;
           end else m_cnt <= m_cnt + 1;
        5: if (dr_result_ack_o) begin
             m_log.push_back(5);
             dr_result_done_i <= 1'b0;
             dr_result_i      <= '0;
             m_log.push_back(6);
             m_st <= 6;
           end
        6: if (!dr_result_ack_o) begin
             m_log.push_back(7);
             m_st <= 0;
           end
        default: m_st <= 0;
      endcase
    end
  end

  // Grant monitor.
  int g_q[$];
  always @(negedge clk) begin
    if (arst) for (int i = 0; i < N_REQ; i++) if (req_ready_o[i]) g_q.push_back(i);
  end

  task automatic grant_req(input int r, input logic [SIZE:0] op, input string nm);
    logic ok = 1'b0;
    req_op[r]      = op;
    req_valid_i[r] = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (req_ready_o[r]) begin ok = 1'b1; break; end
    end
    check({nm, "_grant"}, 64'(ok), 64'd1);
    if (ok) check({nm, "_enc"}, 64'(dr_data_o), 64'(bench_enc(op)));
    req_valid_i[r] = 1'b0;
  endtask

  task automatic finish_rsp(input int id, input logic [SIZE:0] exp, input string nm);
    logic ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (rsp_valid_o) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check({nm, "_rsp_valid"}, 64'(ok), 64'd1);
    if (ok) begin
      check({nm, "_rsp_id"}, 64'(rsp_id_o), 64'(id));
      check({nm, "_rsp_data"}, 64'(rsp_data_o), 64'(exp));
      rsp_ready_i = 1'b1;
      @(negedge clk);
      rsp_ready_i = 1'b0;
      check({nm, "_rsp_drop"}, 64'(rsp_valid_o), 64'd0);
    end
  endtask

  task automatic check_reset_vals(input string nm);
    check({nm, "_dr_data"}, 64'(dr_data_o), 64'd0);
    check({nm, "_res_ack"}, 64'(dr_result_ack_o), 64'd0);
    check({nm, "_ready"}, 64'(req_ready_o), 64'd0);
    check({nm, "_rsp"}, 64'({rsp_valid_o, rsp_id_o, rsp_data_o}), 64'd0);
    check({nm, "_errs"}, 64'({err_timeout_o, err_rail_o}), 64'd0);
  endtask

  typedef struct {
    int            r;
    logic [SIZE:0] op;
    logic [SIZE:0] exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{r: 2, op: 17'h00051, exp: 17'd9};
    vecs[1] = '{r: 0, op: 17'h00000, exp: 17'd0};
    vecs[2] = '{r: 1, op: 17'h00001, exp: 17'd1};
    vecs[3] = '{r: 3, op: 17'h0FFFF, exp: 17'd255};
    vecs[4] = '{r: 2, op: 17'h1FFFF, exp: 17'd362};
    vecs[5] = '{r: 0, op: 17'd100,   exp: 17'd10};

    arst        = 1'b0;
    m_ack_en    = 1'b1;
    m_corrupt   = '0;
    m_unstable  = 1'b0;
    rsp_ready_i = 1'b0;
    req_valid_i = '0;
    for (int i = 0; i < N_REQ; i++) req_op[i] = '0;

    // Reset with random activity on the inputs.
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      req_valid_i = 4'($urandom);
      rsp_ready_i = 1'($urandom);
      for (int i = 0; i < N_REQ; i++) req_op[i] = 17'($urandom);
    end
    @(negedge clk);
    check_reset_vals("reset");
    req_valid_i = '0;
    rsp_ready_i = 1'b0;
    @(negedge clk);
    arst = 1'b1;
    repeat (3) @(negedge clk);

    // Fairness with all four requesters valid, starting from rr_ptr 0.
    g_q.delete();
    for (int i = 0; i < N_REQ; i++) req_op[i] = 17'(i + 4);
    rsp_ready_i = 1'b1;
    req_valid_i = 4'b1111;
    for (int n = 0; n < 1000 && g_q.size() < 5; n++) @(negedge clk);
    req_valid_i = '0;
    check("fair4_count", 64'(g_q.size()), 64'd5);
    if (g_q.size() >= 5) begin
      int exp4[5] = '{0, 1, 2, 3, 0};
      for (int k = 0; k < 5; k++) check($sformatf("fair4_g%0d", k), 64'(g_q[k]), 64'(exp4[k]));
    end
    repeat (60) @(negedge clk);
    g_q.delete();
    req_valid_i = 4'b1010;
    for (int n = 0; n < 1000 && g_q.size() < 4; n++) @(negedge clk);
    req_valid_i = '0;
    check("fair2_count", 64'(g_q.size()), 64'd4);
    if (g_q.size() >= 4) begin
      int exp2[4] = '{1, 3, 1, 3};
      for (int k = 0; k < 4; k++) check($sformatf("fair2_g%0d", k), 64'(g_q[k]), 64'(exp2[k]));
    end
    repeat (60) @(negedge clk);
    rsp_ready_i = 1'b0;

    // Directed single transactions; first one also checks handshake ordering.
    for (int v = 0; v < 6; v++) begin
      m_log.delete();
      g_q.delete();
      grant_req(vecs[v].r, vecs[v].op, $sformatf("vec%0d", v));
      finish_rsp(vecs[v].r, vecs[v].exp, $sformatf("vec%0d", v));
      check($sformatf("vec%0d_one_grant", v), 64'(g_q.size()), 64'd1);
      if (v == 0) begin
        logic [31:0] seq = '0;
        for (int k = 0; k < m_log.size() && k < 8; k++) seq[4*k +: 4] = 4'(m_log[k]);
        check("phase_order", 64'(seq), 64'h07654321);
      end
    end
    check("data_stable", 64'(m_unstable), 64'd0);

    // Response backpressure: outputs hold, no new grant until acceptance.
    grant_req(0, 17'd100, "bp");
    req_op[1]      = 17'd2;
    req_valid_i[1] = 1'b1;
    for (int n = 0; n < 200 && !rsp_valid_o; n++) @(negedge clk);
    g_q.delete();
    for (int n = 0; n < 10; n++) begin
      check($sformatf("bp_hold%0d", n), 64'({rsp_valid_o, rsp_id_o, rsp_data_o}),
            64'({1'b1, 2'd0, 17'd10}));
      @(negedge clk);
    end
    check("bp_no_grant", 64'(g_q.size()), 64'd0);
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    check("bp_accept", 64'({rsp_valid_o, req_ready_o}), 64'd0);
    @(negedge clk);
    check("bp_next_grant", 64'(req_ready_o), 64'b0010);
    req_valid_i[1] = 1'b0;
    finish_rsp(1, 17'd1, "bp2");

    // Timeout: datapath never acks.
    m_ack_en = 1'b0;
    grant_req(3, 17'h0FFFF, "to");
    repeat (10) @(negedge clk);
    check("to_early", 64'(err_timeout_o), 64'd0);
    repeat (7) @(negedge clk);
    check("to_set", 64'(err_timeout_o), 64'd1);
    check("to_still_driven", 64'(dr_data_o), 64'(bench_enc(17'h0FFFF)));
    m_ack_en = 1'b1;
    finish_rsp(3, 17'd255, "to");
    check("to_sticky", 64'(err_timeout_o), 64'd1);

    // Illegal codeword on result bit 3.
    m_corrupt = 17'h00008;
    grant_req(2, 17'h00051, "rail");
    finish_rsp(2, 17'd9, "rail");
    check("rail_err", 64'(err_rail_o), 64'd1);
    m_corrupt = '0;

    // Reset in the middle of an operation.
    m_log.delete();
    grant_req(0, 17'd100, "mid");
    for (int n = 0; n < 100 && m_log.size() < 3; n++) @(negedge clk);
    repeat (2) @(negedge clk);
    arst = 1'b0;
    #1;
    check_reset_vals("mid_reset");
    repeat (3) @(negedge clk);
    arst = 1'b1;
    repeat (2) @(negedge clk);
    grant_req(1, 17'd1, "post");
    finish_rsp(1, 17'd1, "post");
    check("post_errs", 64'({err_timeout_o, err_rail_o}), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
